arbitro_lectura_mux: RTL

Round-robin arbiter that shares the single 16:1 register-read mux among M requesters. It sequences the mux select and registers the mux output back to the winning requester. It is a 2-stage pipeline (grant/select, then capture) with a throughput of one read per cycle. It sits between the requesting units (ALU operand fetch, debug port, etc.) and the register-bank read mux.

---
 rtl/arbitro_lectura_mux_pkg.sv | 7 +
 rtl/arbitro_lectura_mux_rr_prioridad.sv | 26 ++
 rtl/arbitro_lectura_mux.sv | 103 ++++++++++
 3 files changed

// File: rtl/arbitro_lectura_mux_pkg.sv
// Shared constants for the register-bank read/write port arbiters.
// Sizes the read mux select and the register address fields.
package arbitro_pkg;
    localparam int unsigned MUX_SEL_W  = 5;
    localparam int unsigned REG_ADDR_W = 4;
    localparam int unsigned NUM_REGS   = 16;
endpackage

// File: rtl/arbitro_lectura_mux_rr_prioridad.sv
// Combinational round-robin priority search.
// Finds the first set req bit at or above puntero, wrapping M-1 -> 0.
module rr_prioridad #(
    parameter int unsigned M    = 4,
    parameter int unsigned ID_W = $clog2(M)
) (
    input  logic [M-1:0]    req,
    input  logic [ID_W-1:0] puntero,
    output logic            hay_ganador,
    output logic [ID_W-1:0] ganador
);
    logic [ID_W-1:0] cand;

    always_comb begin
        hay_ganador = 1'b0;
        ganador     = '0;
        cand        = '0;
        for (int unsigned i = 0; i < M; i++) begin
            cand = ID_W'((32'(puntero) + i) % M);
            if (!hay_ganador && req[cand]) begin
                hay_ganador = 1'b1;
                ganador     = cand;
            end
        end
    end
endmodule

// File: rtl/arbitro_lectura_mux.sv
// Round-robin arbiter for the shared 16:1 register read mux.
// Stage 1 grants and drives the mux select; stage 2 captures the mux output.
module arbitro_lectura_mux
    import arbitro_pkg::*;
#(
    parameter int unsigned N    = 16,
    parameter int unsigned M    = 4,
    parameter int unsigned ID_W = $clog2(M)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [M-1:0]            req,
    input  logic [REG_ADDR_W*M-1:0] dir,
    input  logic                    pausa,
    output logic [MUX_SEL_W-1:0]    selecm,
    input  logic [N-1:0]            q_in,
    output logic [M-1:0]            gnt,
    output logic [N-1:0]            dato_out,
    output logic                    valido,
    output logic [ID_W-1:0]         id_out
);
    logic [ID_W-1:0]       puntero_q, puntero_d;
    logic [M-1:0]          gnt_q, gnt_d;
    logic [REG_ADDR_W-1:0] sel_q, sel_d;
    logic [ID_W-1:0]       st1_id_q, st1_id_d;
    logic                  st1_v_q, st1_v_d;
    logic [N-1:0]          dato_q, dato_d;
    logic                  valido_q, valido_d;
    logic [ID_W-1:0]       id_q, id_d;

    logic                  hay_ganador;
    logic [ID_W-1:0]       ganador;
    logic [REG_ADDR_W-1:0] dir_ganador;

    rr_prioridad #(
        .M    (M),
        .ID_W (ID_W)
    ) u_prioridad (
        .req         (req),
        .puntero     (puntero_q),
        .hay_ganador (hay_ganador),
        .ganador     (ganador)
    );

    always_comb begin
        dir_ganador = '0;
        for (int unsigned i = 0; i < M; i++) begin
            if (ganador == ID_W'(i)) begin
                dir_ganador = dir[i*REG_ADDR_W +: REG_ADDR_W];
            end
        end

        gnt_d     = '0;
        st1_v_d   = 1'b0;
        st1_id_d  = st1_id_q;
        sel_d     = sel_q;
        puntero_d = puntero_q;
        if (hay_ganador && !pausa) begin
            gnt_d     = M'(1) << ganador;
            st1_v_d   = 1'b1;
            st1_id_d  = ganador;
            sel_d     = dir_ganador;
            puntero_d = (ganador == ID_W'(M - 1)) ? '0 : ganador + 1'b1;
        end

        // Capture stage: q_in reflects the select issued at the previous edge.
        valido_d = st1_v_q;
        dato_d   = dato_q;
        id_d     = id_q;
        if (st1_v_q) begin
            dato_d = q_in;
            id_d   = st1_id_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            puntero_q <= '0;
            gnt_q     <= '0;
            sel_q     <= '0;
            st1_id_q  <= '0;
            st1_v_q   <= 1'b0;
            dato_q    <= '0;
            valido_q  <= 1'b0;
            id_q      <= '0;
        end else begin
            puntero_q <= puntero_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            st1_id_q  <= st1_id_d;
            st1_v_q   <= st1_v_d;
            dato_q    <= dato_d;
            valido_q  <= valido_d;
            id_q      <= id_d;
        end
    end

    assign selecm   = {1'b0, sel_q};
    assign gnt      = gnt_q;
    assign dato_out = dato_q;
    assign valido   = valido_q;
    assign id_out   = id_q;
endmodule
